// File: rtl/norm_round_unit.sv
// Post-add normalisation and round-to-nearest-even datapath: holds the raw sum,
// shifts it under external control, rounds, and commits the exponent with flags.
module norm_round_unit #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  localparam int NBITS       = $clog2(MANTISSABITS)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Load,
  input  logic [MANTISSABITS+1:0]   SumIn,
  input  logic [2:0]                GRSIn,
  input  logic [EXPBITS-1:0]        ExpIn,
  input  logic                      SREn,
  input  logic                      SLEn,
  input  logic                      IncrEn,
  input  logic                      DecrEn,
  input  logic [NBITS-1:0]          ShiftAmount,
  input  logic                      SelManMuxR,
  input  logic                      SelExpMuxR,
  output logic                      FFOValid,
  output logic [NBITS-1:0]          FFOIndex,
  output logic [MANTISSABITS+1:0]   Out,
  output logic [EXPBITS-1:0]        ResultExp,
  output logic                      Done,
  output logic                      Overflow,
  output logic                      Underflow
);

  localparam int MW = MANTISSABITS + 2;
  localparam logic [EXPBITS-1:0] EXP_MAX = '1;

  logic [MW-1:0]      man, man_n;
  logic               g, r, s, g_n, r_n, s_n;
  logic [EXPBITS-1:0] exp_q, exp_n, exp_inc, sa_ext, rexp_n;
  logic               ovf_n, unf_n, done_n;
  logic [MW:0]        ext;
  logic               round_up;

  assign Out      = man;
  assign FFOValid = |man;

  // Lowest-to-highest scan so the last hit is the leading one.
  always_comb begin
    FFOIndex = '0;
    for (int i = 0; i < MW; i++) begin
      if (man[i]) FFOIndex = NBITS'(i);
    end
  end

  // Mantissa path: Load > SREn > SLEn > SelManMuxR > hold.
  always_comb begin
    man_n    = man;
    g_n      = g;
    r_n      = r;
    s_n      = s;
    ext      = {man, g} << ShiftAmount;
    round_up = g & (r | s | man[0]);
    if (Load) begin
      man_n = SumIn;
      g_n   = GRSIn[2];
      r_n   = GRSIn[1];
      s_n   = GRSIn[0];
    end else if (SREn) begin
      man_n = {1'b0, man[MW-1:1]};
      g_n   = man[0];
      r_n   = g;
      s_n   = s | r;
    end else if (SLEn) begin
      if (ShiftAmount != '0) begin
        man_n = ext[MW:1];
        g_n   = ext[0];
        r_n   = 1'b0;
        s_n   = 1'b0;
      end
    end else if (SelManMuxR) begin
      man_n = man + MW'(round_up);
      g_n   = 1'b0;
      r_n   = 1'b0;
      s_n   = 1'b0;
    end
  end

  // Exponent path; simultaneous increment and decrement cancel out.
  always_comb begin
    exp_n   = exp_q;
    ovf_n   = Overflow;
    unf_n   = Underflow;
    exp_inc = exp_q + EXPBITS'(1);
    sa_ext  = EXPBITS'(ShiftAmount);
    if (Load) begin
      exp_n = ExpIn;
      ovf_n = 1'b0;
      unf_n = 1'b0;
    end else if (IncrEn && !DecrEn) begin
      if (exp_inc == EXP_MAX || exp_q == EXP_MAX) begin
        exp_n = EXP_MAX;
        ovf_n = 1'b1;
      end else begin
        exp_n = exp_inc;
      end
    end else if (DecrEn && !IncrEn) begin
      if (exp_q <= sa_ext) begin
        exp_n = '0;
        unf_n = 1'b1;
      end else begin
        exp_n = exp_q - sa_ext;
      end
    end
  end

  // A Load in the same cycle aborts the commit.
  always_comb begin
    done_n = SelExpMuxR & ~Load;
    rexp_n = ResultExp;
    if (done_n) rexp_n = FFOValid ? exp_q : '0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      man       <= '0;
      g         <= 1'b0;
      r         <= 1'b0;
      s         <= 1'b0;
      exp_q     <= '0;
      ResultExp <= '0;
      Done      <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      man       <= man_n;
      g         <= g_n;
      r         <= r_n;
      s         <= s_n;
      exp_q     <= exp_n;
      ResultExp <= rexp_n;
      Done      <= done_n;
      Overflow  <= ovf_n;
      Underflow <= unf_n;
    end
  end

endmodule

// File: tb/tb_norm_round_unit.sv
// Bench for norm_round_unit: directed scenarios plus randomized control
// sequences checked against an arithmetic reference model.
module tb_norm_round_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Load, SREn, SLEn, IncrEn, DecrEn, SelManMuxR, SelExpMuxR;
  logic [24:0] SumIn;
  logic [2:0]  GRSIn;
  logic [7:0]  ExpIn;
  logic [4:0]  ShiftAmount;
  logic        FFOValid;
  logic [4:0]  FFOIndex;
  logic [24:0] Out;
  logic [7:0]  ResultExp;
  logic        Done, Overflow, Underflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  longint m_man;
  int     m_g, m_r, m_s, m_exp, m_rexp;
  bit     m_done, m_ov, m_un;

  norm_round_unit dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .SumIn(SumIn), .GRSIn(GRSIn),
    .ExpIn(ExpIn), .SREn(SREn), .SLEn(SLEn), .IncrEn(IncrEn), .DecrEn(DecrEn),
    .ShiftAmount(ShiftAmount), .SelManMuxR(SelManMuxR), .SelExpMuxR(SelExpMuxR),
    .FFOValid(FFOValid), .FFOIndex(FFOIndex), .Out(Out), .ResultExp(ResultExp),
    .Done(Done), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  task automatic idle_inputs();
    Load = 0; SREn = 0; SLEn = 0; IncrEn = 0; DecrEn = 0;
    SelManMuxR = 0; SelExpMuxR = 0; SumIn = '0; GRSIn = '0; ExpIn = '0; ShiftAmount = '0;
  endtask

  task automatic model_reset();
    m_man = 0; m_g = 0; m_r = 0; m_s = 0; m_exp = 0; m_rexp = 0;
    m_done = 0; m_ov = 0; m_un = 0;
  endtask

  // Apply one cycle of controls to DUT and model; returns at posedge+1.
  task automatic drive(input bit ld, input logic [24:0] sum, input logic [2:0] grs,
                       input logic [7:0] e, input bit sre, input bit sle, input bit inc,
                       input bit dec, input logic [4:0] sa, input bit rnd, input bit cmt);
    longint nman, v;
    int ng, nr, ns, ne, nrexp, up;
    bit nov, nun, ndone;
    Load = ld; SumIn = sum; GRSIn = grs; ExpIn = e; SREn = sre; SLEn = sle;
    IncrEn = inc; DecrEn = dec; ShiftAmount = sa; SelManMuxR = rnd; SelExpMuxR = cmt;
    nman = m_man; ng = m_g; nr = m_r; ns = m_s; ne = m_exp; nov = m_ov; nun = m_un;
    nrexp = m_rexp;
    if (ld) begin
      nman = sum; ng = grs[2]; nr = grs[1]; ns = grs[0];
    end else if (sre) begin
      nman = m_man / 2; ng = int'(m_man % 2); nr = m_g; ns = m_s | m_r;
    end else if (sle) begin
      if (sa != 0) begin
        v = (m_man * 2 + m_g) << sa;
        nman = (v >> 1) % (64'd1 << 25); ng = 0; nr = 0; ns = 0;
      end
    end else if (rnd) begin
      up = (m_g == 1 && (m_r == 1 || m_s == 1 || m_man % 2 == 1)) ? 1 : 0;
      nman = (m_man + up) % (64'd1 << 25); ng = 0; nr = 0; ns = 0;
    end
    if (ld) begin
      ne = e; nov = 0; nun = 0;
    end else if (inc && !dec) begin
      if (m_exp + 1 >= 255) begin ne = 255; nov = 1; end
      else ne = m_exp + 1;
    end else if (dec && !inc) begin
      if (m_exp <= int'(sa)) begin ne = 0; nun = 1; end
      else ne = m_exp - int'(sa);
    end
    ndone = cmt && !ld;
    if (ndone) nrexp = (m_man != 0) ? m_exp : 0;
    @(posedge Clock);
    #1;
    m_man = nman; m_g = ng; m_r = nr; m_s = ns; m_exp = ne; m_ov = nov; m_un = nun;
    m_done = ndone; m_rexp = nrexp;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    total_cnt++; if (Out !== 25'h0) $display("FAIL reset_out: got %h expected 0", Out); else pass_cnt++;
    total_cnt++; if (FFOValid !== 1'b0 || FFOIndex !== 5'd0)
      $display("FAIL reset_ffo: got %b/%0d expected 0/0", FFOValid, FFOIndex); else pass_cnt++;
    total_cnt++; if ({ResultExp, Done, Overflow, Underflow} !== 11'h0)
      $display("FAIL reset_flags: got %h/%b%b%b expected 0", ResultExp, Done, Overflow, Underflow);
    else pass_cnt++;
    Reset = 1;
  endtask

  task automatic test_right_norm();
    drive(1, 25'h1000000, 3'b000, 8'h80, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (FFOIndex !== 5'd24 || FFOValid !== 1'b1)
      $display("FAIL rn_ffo: got %0d expected 24", FFOIndex); else pass_cnt++;
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    total_cnt++; if (Out !== 25'h0800000) $display("FAIL rn_out: got %h expected 0800000", Out);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    total_cnt++; if (Out !== 25'h0800000) $display("FAIL rn_round_g0: got %h expected 0800000", Out);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    total_cnt++; if (ResultExp !== 8'h81 || Done !== 1'b1)
      $display("FAIL rn_commit: got %h/%b expected 81/1", ResultExp, Done); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (Done !== 1'b0) $display("FAIL rn_done_pulse: got %b expected 0", Done);
    else pass_cnt++;
  endtask

  task automatic test_left_norm();
    drive(1, 25'h0000400, 3'b000, 8'h20, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (FFOIndex !== 5'd10) $display("FAIL ln_ffo: got %0d expected 10", FFOIndex);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 1, 0, 1, 5'd13, 0, 0);
    total_cnt++; if (Out !== 25'h0800000) $display("FAIL ln_out: got %h expected 0800000", Out);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    total_cnt++; if (ResultExp !== 8'h13 || Done !== 1'b1)
      $display("FAIL ln_commit: got %h/%b expected 13/1", ResultExp, Done); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (Done !== 1'b0) $display("FAIL ln_done_pulse: got %b expected 0", Done);
    else pass_cnt++;
  endtask

  task automatic test_round();
    drive(1, 25'h0FFFFFF, 3'b100, 8'h10, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    total_cnt++; if (Out !== 25'h1000000) $display("FAIL rnd_carry: got %h expected 1000000", Out);
    else pass_cnt++;
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    total_cnt++; if (Out !== 25'h0800000) $display("FAIL rnd_renorm: got %h expected 0800000", Out);
    else pass_cnt++;
    drive(1, 25'h0800000, 3'b100, 8'h10, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    total_cnt++; if (Out !== 25'h0800000) $display("FAIL rnd_tie_even: got %h expected 0800000", Out);
    else pass_cnt++;
    drive(1, 25'h0800001, 3'b100, 8'h10, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    total_cnt++; if (Out !== 25'h0800002) $display("FAIL rnd_tie_odd: got %h expected 0800002", Out);
    else pass_cnt++;
    drive(1, 25'h0800000, 3'b101, 8'h10, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    total_cnt++; if (Out !== 25'h0800001) $display("FAIL rnd_sticky: got %h expected 0800001", Out);
    else pass_cnt++;
  endtask

  task automatic test_exp_flags();
    drive(1, 25'h0800000, 3'b000, 8'hFE, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    total_cnt++; if (Overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", Overflow);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    total_cnt++; if (ResultExp !== 8'hFF || Overflow !== 1'b1)
      $display("FAIL ovf_sat: got %h/%b expected FF/1", ResultExp, Overflow); else pass_cnt++;
    drive(1, 25'h0800000, 3'b000, 8'h03, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (Overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", Overflow);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 1, 1, 5'd5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    total_cnt++; if (ResultExp !== 8'h03 || Underflow !== 1'b0)
      $display("FAIL incdec_cancel: got %h/%b expected 03/0", ResultExp, Underflow); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    total_cnt++; if (ResultExp !== 8'h00 || Underflow !== 1'b1)
      $display("FAIL unf_set: got %h/%b expected 00/1", ResultExp, Underflow); else pass_cnt++;
    drive(1, 25'h0800000, 3'b000, 8'h40, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (Underflow !== 1'b0 || Overflow !== 1'b0)
      $display("FAIL unf_clear: got %b%b expected 00", Overflow, Underflow); else pass_cnt++;
  endtask

  task automatic test_zero();
    drive(1, 25'h0, 3'b000, 8'h55, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (FFOValid !== 1'b0 || FFOIndex !== 5'd0)
      $display("FAIL zero_ffo: got %b/%0d expected 0/0", FFOValid, FFOIndex); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    total_cnt++; if (ResultExp !== 8'h00 || Done !== 1'b1)
      $display("FAIL zero_commit: got %h/%b expected 00/1", ResultExp, Done); else pass_cnt++;
  endtask

  task automatic test_sre_sle_together();
    drive(1, 25'h0000006, 3'b000, 8'h10, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 5'd3, 0, 0);
    total_cnt++; if (Out !== 25'h0000003) $display("FAIL sre_sle: got %h expected 0000003", Out);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    drive(1, 25'h0123456, 3'b010, 8'h44, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    total_cnt++; if (Done !== 1'b1 || ResultExp !== 8'h44)
      $display("FAIL ar_pre: got %b/%h expected 1/44", Done, ResultExp); else pass_cnt++;
    #3;
    Reset = 0;
    #1;
    model_reset();
    total_cnt++; if ({Out, FFOValid, FFOIndex, ResultExp, Done, Overflow, Underflow} !== 42'h0)
      $display("FAIL ar_clear: got %h/%b/%0d/%h/%b expected all 0", Out, FFOValid, FFOIndex,
               ResultExp, Done);
    else pass_cnt++;
    @(negedge Clock);
    Reset = 1;
    drive(1, 25'h00ABCDE, 3'b000, 8'h21, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (Out !== 25'h00ABCDE) $display("FAIL ar_first_load: got %h expected 00abcde", Out);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [24:0] sum;
    bit ld;
    for (int i = 0; i < 400; i++) begin
      sum = 25'($urandom) >> $urandom_range(0, 24);
      ld = ($urandom_range(0, 5) == 0);
      drive(ld, sum, 3'($urandom), 8'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 5'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0);
      total_cnt++; if (Out !== m_man[24:0])
        $display("FAIL rand_out[%0d]: got %h expected %h", i, Out, m_man[24:0]); else pass_cnt++;
      total_cnt++; if (FFOValid !== (m_man != 0) ||
                       FFOIndex !== ((m_man == 0) ? 5'd0 : 5'($clog2(m_man + 1) - 1)))
        $display("FAIL rand_ffo[%0d]: got %b/%0d for man %h", i, FFOValid, FFOIndex, m_man[24:0]);
      else pass_cnt++;
      total_cnt++; if (ResultExp !== 8'(m_rexp) || Done !== m_done)
        $display("FAIL rand_commit[%0d]: got %h/%b expected %h/%b", i, ResultExp, Done,
                 8'(m_rexp), m_done);
      else pass_cnt++;
      total_cnt++; if (Overflow !== m_ov || Underflow !== m_un)
        $display("FAIL rand_flags[%0d]: got %b%b expected %b%b", i, Overflow, Underflow, m_ov, m_un);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_right_norm();
    test_left_norm();
    test_round();
    test_exp_flags();
    test_zero();
    test_sre_sle_together();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/norm_round_unit.md
NORM_ROUND_UNIT -- requirements
Module: norm_round_unit

Interface
REQ-001 SHALL have parameter EXPBITS, 8, exponent width.
REQ-002 SHALL have parameter MANTISSABITS, 23, stored fraction width; NBITS = $clog2(MANTISSABITS) (5 at default).
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset (Reset=0 resets).
REQ-005 SHALL have port Load  input  1  strobe: capture raw adder sum, GRS bits and exponent.
REQ-006 SHALL have port SumIn  input  MANTISSABITS+2  raw sum {carry, hidden, fraction}.
REQ-007 SHALL have port GRSIn  input  3  {guard, round, sticky} from alignment.
REQ-008 SHALL have port ExpIn  input  EXPBITS  larger operand exponent.
REQ-009 SHALL have port SREn  input  1  right-shift mantissa by 1.
REQ-010 SHALL have port SLEn  input  1  left-shift mantissa by ShiftAmount.
REQ-011 SHALL have port IncrEn  input  1  exponent +1.
REQ-012 SHALL have port DecrEn  input  1  exponent -ShiftAmount.
REQ-013 SHALL have port ShiftAmount  input  NBITS  left-shift / decrement amount.
REQ-014 SHALL have port SelManMuxR  input  1  perform rounding step.
REQ-015 SHALL have port SelExpMuxR  input  1  commit result.
REQ-016 SHALL have port FFOValid  output  1  mantissa register nonzero.
REQ-017 SHALL have port FFOIndex  output  NBITS  bit index of most-significant 1 in mantissa register (0..MANTISSABITS+1).
REQ-018 SHALL have port Out  output  MANTISSABITS+2  current mantissa register.
REQ-019 SHALL have port ResultExp  output  EXPBITS  committed exponent.
REQ-020 SHALL have port Done, Overflow, Underflow  output  1 each  commit pulse; sticky exponent flags.

Function
REQ-021 SHALL hold state: Man (MANTISSABITS+2), G, R, S, Exp (EXPBITS), ResultExp, Overflow, Underflow, Done.
REQ-022 SHALL drive Out=Man and FFOValid/FFOIndex combinationally from Man (0-cycle latency after Man updates); FFOIndex=0 when Man=0.
REQ-023 SHALL apply per-cycle mantissa priority: Load > SREn > SLEn > SelManMuxR > hold; SREn with SLEn executes SREn only.
REQ-024 Load SHALL set Man=SumIn, {G,R,S}=GRSIn, Exp=ExpIn, clear Overflow/Underflow, abort any in-progress sequence.
REQ-025 SREn SHALL set Man=Man>>1 (MSB 0), G=old Man[0], R=old G, S=old S|old R.
REQ-026 SLEn SHALL shift {Man,G} left by ShiftAmount, zero-fill, keep upper MANTISSABITS+2 bits; R=S=0; ShiftAmount=0 is a no-op.
REQ-027 SelManMuxR SHALL round to nearest even: up = G&(R|S|Man[0]); Man=Man+up (carry into MSB kept, visible on Out next cycle); G=R=S=0.
REQ-028 IncrEn SHALL set Exp=Exp+1; if result is all ones, Overflow=1 and Exp saturates at all ones.
REQ-029 DecrEn SHALL set Exp=Exp-ShiftAmount; if Exp<=ShiftAmount, Exp=0 and Underflow=1.
REQ-030 IncrEn with DecrEn SHALL apply neither; Load overrides both.
REQ-031 SelExpMuxR SHALL set ResultExp=Exp (0 if FFOValid=0) and pulse Done for exactly 1 cycle; Done=0 otherwise.
REQ-032 Overflow/Underflow SHALL remain set until next Load or reset.

Reset
REQ-033 Reset=0 SHALL immediately clear Man, G, R, S, Exp, ResultExp, Done, Overflow, Underflow (so Out=0, FFOValid=0, FFOIndex=0), including mid-sequence.
REQ-034 First Load after Reset rises SHALL be accepted on the next rising edge.

Verification
REQ-035 Load SumIn=25'h1000000, ExpIn=8'h80 -> FFOIndex=24; then SREn+IncrEn -> Out=25'h0800000, Exp=8'h81, G=0.
REQ-036 Load SumIn=25'h0000400, ExpIn=8'h20 -> FFOIndex=10; then SLEn+DecrEn, ShiftAmount=13 -> Out=25'h0800000; commit -> ResultExp=8'h13, Done one cycle.
REQ-037 Load SumIn=25'h0FFFFFF, GRSIn=3'b100, round -> Out=25'h1000000 (carry); SREn+IncrEn -> Out=25'h0800000. Load SumIn=25'h0800000, GRSIn=3'b100, round -> Out unchanged (tie to even).
REQ-038 Load ExpIn=8'hFE, IncrEn -> Exp=8'hFF, Overflow=1; Load ExpIn=8'h03, DecrEn ShiftAmount=5 -> Exp=0, Underflow=1; next Load clears both.
REQ-039 Load SumIn=0 -> FFOValid=0, FFOIndex=0; commit -> ResultExp=0, Done=1.
REQ-040 Reset=0 asserted between clock edges mid-sequence -> all outputs 0 before next edge; SREn+SLEn together -> only right shift observed.
